// File: rtl/ram_arb_pkg.sv
// Shared definitions for the SDRAM request-port arbiter: FSM state codes
// and the default watchdog limit.
package ram_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of requester-side and SDRAM-side signals around the arbiter.
// slave: the arbiter's view. master: the view of the surrounding system
// (requesters plus SDRAM controller).
interface ram_arbiter_if #(
  parameter int N  = 2,
  parameter int AW = 23,
  parameter int DW = 32
);
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]        REQ;
  logic [N-1:0]        REQ_WE;
  logic [N*AW-1:0]     REQ_ADDR;
  logic [N*DW-1:0]     REQ_DIN;
  logic [N*DW/8-1:0]   REQ_BE;
  logic [N-1:0]        ACK;
  logic [DW-1:0]       DOUT;
  logic                ERR;
  logic                RAM_REQ;
  logic                RAM_WE;
  logic [AW-1:0]       RAM_ADDR;
  logic [DW-1:0]       RAM_DIN;
  logic [DW/8-1:0]     RAM_BE;
  logic                RAM_ACK;
  logic [DW-1:0]       RAM_DOUT;
  logic [GW-1:0]       GRANT;

  modport slave (
    input  REQ, REQ_WE, REQ_ADDR, REQ_DIN, REQ_BE, RAM_ACK, RAM_DOUT,
    output ACK, DOUT, ERR, RAM_REQ, RAM_WE, RAM_ADDR, RAM_DIN, RAM_BE, GRANT
  );

  modport master (
    output REQ, REQ_WE, REQ_ADDR, REQ_DIN, REQ_BE, RAM_ACK, RAM_DOUT,
    input  ACK, DOUT, ERR, RAM_REQ, RAM_WE, RAM_ADDR, RAM_DIN, RAM_BE, GRANT
  );

endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin finder: returns the first set request bit
// searching upward from ptr_i+1 and wrapping modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          valid_o,
  output logic [PW-1:0] idx_o
);

  // Lowest request above the pointer wins; otherwise wrap to the lowest at or below it.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i] && (PW'(i) <= ptr_i)) begin
        valid_o = 1'b1;
        idx_o   = PW'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i] && (PW'(i) > ptr_i)) begin
        valid_o = 1'b1;
        idx_o   = PW'(i);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one SDRAM user port between N requesters.
// One transaction in flight: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
// Optional watchdog on WAIT selected by macro RAM_ARB_WATCHDOG_EN.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N       = 2,
  parameter int AW      = 23,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic          CLK,
  input logic          RESET,
  ram_arbiter_if.slave bus
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = DW / 8;

  logic [1:0]    state_q,   state_d;
  logic [GW-1:0] grant_q,   grant_d;
  logic [N-1:0]  ack_q,     ack_d;
  logic [DW-1:0] dout_q,    dout_d;
  logic          ram_req_q, ram_req_d;
  logic          we_q,      we_d;
  logic [AW-1:0] addr_q,    addr_d;
  logic [DW-1:0] din_q,     din_d;
  logic [BW-1:0] be_q,      be_d;

  logic          pick_vld;
  logic [GW-1:0] pick_idx;

`ifdef RAM_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  rr_pick #(.N(N), .PW(GW)) u_pick (
    .req_i   (bus.REQ),
    .ptr_i   (grant_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  // Next-state logic: grant and latch in IDLE, raise request in ISSUE, wait for completion.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ack_d     = '0;
    dout_d    = dout_q;
    ram_req_d = ram_req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    din_d     = din_q;
    be_d      = be_q;
`ifdef RAM_ARB_WATCHDOG_EN
    cnt_d     = cnt_q;
    err_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          we_d    = bus.REQ_WE[pick_idx];
          addr_d  = bus.REQ_ADDR[int'(pick_idx) * AW +: AW];
          din_d   = bus.REQ_DIN[int'(pick_idx) * DW +: DW];
          be_d    = bus.REQ_BE[int'(pick_idx) * BW +: BW];
          state_d = ST_ISSUE;
`ifdef RAM_ARB_WATCHDOG_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_ISSUE: begin
        ram_req_d = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.RAM_ACK) begin
          ram_req_d      = 1'b0;
          dout_d         = bus.RAM_DOUT;
          ack_d[grant_q] = 1'b1;
          state_d        = ST_DONE;
        end
`ifdef RAM_ARB_WATCHDOG_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          ram_req_d      = 1'b0;
          dout_d         = '1;
          ack_d[grant_q] = 1'b1;
          err_d          = 1'b1;
          state_d        = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction without ACK.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      grant_q   <= GW'(N - 1);
      ack_q     <= '0;
      dout_q    <= '0;
      ram_req_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      be_q      <= '0;
`ifdef RAM_ARB_WATCHDOG_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      dout_q    <= dout_d;
      ram_req_q <= ram_req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      be_q      <= be_d;
`ifdef RAM_ARB_WATCHDOG_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign bus.ACK      = ack_q;
  assign bus.DOUT     = dout_q;
  assign bus.RAM_REQ  = ram_req_q;
  assign bus.RAM_WE   = we_q;
  assign bus.RAM_ADDR = addr_q;
  assign bus.RAM_DIN  = din_q;
  assign bus.RAM_BE   = be_q;
  assign bus.GRANT    = grant_q;
`ifdef RAM_ARB_WATCHDOG_EN
  assign bus.ERR      = err_q;
`else
  assign bus.ERR      = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed steps plus a randomized round-robin run
// against a modulo-arithmetic arbitration model.
module tb_ram_arbiter;

  localparam int N  = 2;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int BW = DW / 8;
`ifdef RAM_ARB_WATCHDOG_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus ();

  ram_arbiter #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ptr;
  logic [DW-1:0] last_dout;

  logic          a_we   [N];
  logic [AW-1:0] a_addr [N];
  logic [DW-1:0] a_din  [N];
  logic [BW-1:0] a_be   [N];
  logic [N-1:0]  reqv;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.REQ = reqv;
    for (int i = 0; i < N; i++) begin
      bus.REQ_WE[i]              = a_we[i];
      bus.REQ_ADDR[i*AW +: AW]   = a_addr[i];
      bus.REQ_DIN[i*DW +: DW]    = a_din[i];
      bus.REQ_BE[i*BW +: BW]     = a_be[i];
    end
  endtask

  task automatic rand_fields(input int i);
    a_we[i]   = 1'($urandom_range(0, 1));
    a_addr[i] = AW'($urandom);
    a_din[i]  = $urandom;
    a_be[i]   = BW'($urandom);
  endtask

  // Reference arbitration: first requester at (p+k) mod N, k = 1..N.
  function automatic int model_pick(input logic [N-1:0] r, input int p);
    int rv;
    rv = int'(r);
    for (int k = 1; k <= N; k++) begin
      if (((rv >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
    end
    return -1;
  endfunction

  // One transaction for expected winner w; RAM answers dly cycles after RAM_REQ.
  task automatic txn(input int w, input int dly, input logic [DW-1:0] rd,
                     input int exp_gap, input bit scramble);
    int t;
    t = 0;
    while (bus.RAM_REQ !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    chk("ram_req_rise", 64'(bus.RAM_REQ), 64'(1));
    if (exp_gap >= 0) chk("req_latency", 64'(t), 64'(exp_gap));
    chk("grant", 64'(bus.GRANT), 64'(w));
    chk("ram_we", 64'(bus.RAM_WE), 64'(a_we[w]));
    chk("ram_addr", 64'(bus.RAM_ADDR), 64'(a_addr[w]));
    chk("ram_din", 64'(bus.RAM_DIN), 64'(a_din[w]));
    chk("ram_be", 64'(bus.RAM_BE), 64'(a_be[w]));
    if (scramble) begin
      bus.REQ[w]                 = 1'b0;
      bus.REQ_ADDR[w*AW +: AW]   = ~a_addr[w];
      bus.REQ_DIN[w*DW +: DW]    = ~a_din[w];
      bus.REQ_BE[w*BW +: BW]     = ~a_be[w];
    end
    for (int k = 0; k < dly; k++) begin
      step();
      chk("hold_req", 64'(bus.RAM_REQ), 64'(1));
      chk("hold_addr", 64'(bus.RAM_ADDR), 64'(a_addr[w]));
      chk("hold_din", 64'(bus.RAM_DIN), 64'(a_din[w]));
      chk("hold_be", 64'(bus.RAM_BE), 64'(a_be[w]));
      chk("no_early_ack", 64'(bus.ACK), 64'(0));
    end
    bus.RAM_ACK  = 1'b1;
    bus.RAM_DOUT = rd;
    step();
    bus.RAM_ACK  = 1'b0;
    bus.RAM_DOUT = $urandom;
    chk("ack", 64'(bus.ACK), 64'(1 << w));
    chk("dout", 64'(bus.DOUT), 64'(rd));
    chk("err_low", 64'(bus.ERR), 64'(0));
    chk("ram_req_drop", 64'(bus.RAM_REQ), 64'(0));
    ptr       = w;
    last_dout = rd;
    step();
    chk("ack_single", 64'(bus.ACK), 64'(0));
  endtask

  initial begin
    int w;
    int t;
    rst          = 1'b1;
    bus.RAM_ACK  = 1'b0;
    bus.RAM_DOUT = '0;
    reqv         = '0;
    for (int i = 0; i < N; i++) begin
      a_we[i] = 1'b0; a_addr[i] = '0; a_din[i] = '0; a_be[i] = '0;
    end
    drive();
    repeat (3) step();

    // Reset values
    chk("rst_ack", 64'(bus.ACK), 64'(0));
    chk("rst_err", 64'(bus.ERR), 64'(0));
    chk("rst_dout", 64'(bus.DOUT), 64'(0));
    chk("rst_ram_req", 64'(bus.RAM_REQ), 64'(0));
    chk("rst_ram_we", 64'(bus.RAM_WE), 64'(0));
    chk("rst_ram_addr", 64'(bus.RAM_ADDR), 64'(0));
    chk("rst_ram_din", 64'(bus.RAM_DIN), 64'(0));
    chk("rst_ram_be", 64'(bus.RAM_BE), 64'(0));
    chk("rst_grant", 64'(bus.GRANT), 64'(N - 1));
    rst = 1'b0;
    ptr = N - 1;
    last_dout = '0;

    // Single read from requester 0
    a_addr[0] = 23'h000123; a_we[0] = 1'b0; a_din[0] = 32'h0; a_be[0] = 4'hF;
    reqv = 2'b01;
    drive();
    txn(0, 5, 32'hDEADBEEF, 2, 1'b0);
    reqv = '0;
    drive();
    step();
    chk("dout_kept", 64'(bus.DOUT), 64'(32'hDEADBEEF));

    // Contention from reset pointer: grants 0,1,0,1
    rst = 1'b1;
    step();
    rst = 1'b0;
    ptr = N - 1;
    for (int i = 0; i < N; i++) rand_fields(i);
    reqv = 2'b11;
    drive();
    for (int k = 0; k < 4; k++) txn(k % 2, 0, $urandom, 2, 1'b0);
    reqv = '0;
    drive();

    // Write on requester 1; REQ dropped and fields changed mid-transaction
    a_we[1] = 1'b1; a_din[1] = 32'h12345678; a_be[1] = 4'b0101; a_addr[1] = 23'h2A5A5A;
    reqv = 2'b10;
    drive();
    txn(1, 10, 32'hCAFEF00D, 2, 1'b1);
    reqv = '0;
    drive();

    // Spurious RAM_ACK while idle
    bus.RAM_ACK  = 1'b1;
    bus.RAM_DOUT = 32'hA5A5A5A5;
    step();
    bus.RAM_ACK  = 1'b0;
    chk("spur_ack", 64'(bus.ACK), 64'(0));
    chk("spur_dout", 64'(bus.DOUT), 64'(last_dout));
    step();
    chk("spur_ram_req", 64'(bus.RAM_REQ), 64'(0));
    chk("spur_dout2", 64'(bus.DOUT), 64'(last_dout));

    // RAM_ACK during ISSUE is ignored
    rand_fields(0);
    reqv = 2'b01;
    drive();
    step();
    bus.RAM_ACK  = 1'b1;
    bus.RAM_DOUT = 32'h5A5A5A5A;
    step();
    bus.RAM_ACK  = 1'b0;
    chk("issue_ack_ignored", 64'(bus.ACK), 64'(0));
    chk("issue_dout_kept", 64'(bus.DOUT), 64'(last_dout));
    txn(model_pick(reqv, ptr), 3, $urandom, -1, 1'b0);

    // Randomized traffic against the round-robin model
    for (int i = 0; i < N; i++) if (!reqv[i]) rand_fields(i);
    reqv = N'($urandom_range(1, (1 << N) - 1));
    for (int i = 0; i < N; i++) if (reqv[i]) rand_fields(i);
    drive();
    for (int it = 0; it < 40; it++) begin
      w = model_pick(reqv, ptr);
      txn(w, $urandom_range(0, 6), $urandom, 2, 1'b0);
      for (int i = 0; i < N; i++) begin
        if (i == w || !reqv[i]) begin
          reqv[i] = 1'($urandom_range(0, 1));
          if (reqv[i]) rand_fields(i);
        end
      end
      if (reqv == '0) begin
        w = $urandom_range(0, N - 1);
        reqv[w] = 1'b1;
        rand_fields(w);
      end
      drive();
    end
    txn(model_pick(reqv, ptr), 1, $urandom, 2, 1'b0);
    reqv = '0;
    drive();
    repeat (2) step();

    // Reset while waiting on the RAM abandons the transaction
    rand_fields(0);
    reqv = 2'b01;
    drive();
    t = 0;
    while (bus.RAM_REQ !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    chk("rw_ram_req_rise", 64'(bus.RAM_REQ), 64'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    reqv = '0;
    drive();
    chk("rw_ram_req", 64'(bus.RAM_REQ), 64'(0));
    chk("rw_ack", 64'(bus.ACK), 64'(0));
    chk("rw_grant", 64'(bus.GRANT), 64'(N - 1));
    chk("rw_ram_addr", 64'(bus.RAM_ADDR), 64'(0));
    bus.RAM_ACK  = 1'b1;
    bus.RAM_DOUT = 32'h01020304;
    step();
    bus.RAM_ACK  = 1'b0;
    chk("rw_late_ack", 64'(bus.ACK), 64'(0));
    step();
    chk("rw_late_ack2", 64'(bus.ACK), 64'(0));
    chk("rw_dout", 64'(bus.DOUT), 64'(0));
    ptr = N - 1;

`ifdef RAM_ARB_WATCHDOG_EN
    // Watchdog: RAM never answers
    rand_fields(0);
    reqv = 2'b01;
    drive();
    t = 0;
    while (bus.RAM_REQ !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    chk("wd_ram_req_rise", 64'(bus.RAM_REQ), 64'(1));
    t = 0;
    while (bus.RAM_REQ === 1'b1 && t < 40) begin
      step();
      t++;
    end
    reqv = '0;
    drive();
    chk("wd_cycles", 64'(t), 64'(TO));
    chk("wd_ack", 64'(bus.ACK), 64'(1));
    chk("wd_err", 64'(bus.ERR), 64'(1));
    chk("wd_dout", 64'(bus.DOUT), 64'(32'hFFFFFFFF));
    bus.RAM_ACK  = 1'b1;
    bus.RAM_DOUT = 32'h11111111;
    step();
    bus.RAM_ACK  = 1'b0;
    chk("wd_ack_end", 64'(bus.ACK), 64'(0));
    chk("wd_err_end", 64'(bus.ERR), 64'(0));
    step();
    chk("wd_late_ack", 64'(bus.ACK), 64'(0));
    chk("wd_dout_kept", 64'(bus.DOUT), 64'(32'hFFFFFFFF));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
